sofm_bmu_search: RTL and testbench

Best-matching-unit search stage in front of the SOFM weight-update engine. On a start pulse it caches one input sample from the 16-bit input memory, then streams every neuron's weights from the 64-bit map memory and computes the squared Euclidean distance per neuron. It reports the winning neuron's (x,y) coordinates and distance, which the update stage then uses as its winner position.

---
 rtl/sofm_pkg.sv | 23 ++
 rtl/sofm_bmu_search_sqdist.sv | 45 ++++
 rtl/sofm_bmu_search.sv | 225 ++++++++++++++++++++++
 tb/tb_sofm_bmu_search.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sofm_pkg.sv
// Shared types and helpers for the SOFM best-matching-unit search.
package sofm_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SCAN,
      DRAIN,
      DONE
   } state_t;

   localparam int LANES  = 4;
   localparam int LANE_W = 16;
   localparam int WORD_W = 64;

   // Number of 64-bit map words holding one neuron of d elements.
   function automatic logic [15:0] words_per_neuron(input logic [15:0] d);
      logic [16:0] t;
      t = {1'b0, d} + 17'd3;
      return {1'b0, t[16:2]};
   endfunction

endpackage

// File: rtl/sofm_bmu_search_sqdist.sv
// Four-lane masked squared-difference sum with a registered result.
module sofm_sqdist4
   import sofm_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] word,
   input  logic [WORD_W-1:0] sample,
   input  logic [LANES-1:0]  mask,
   output logic [35:0]       sum
);

   logic [35:0]       sum_c;
   logic [LANE_W-1:0] a;
   logic [LANE_W-1:0] b;
   logic [LANE_W-1:0] ad;
   logic [33:0]       sq;

   // |a-b| squared equals (a-b)^2 and keeps the multiplier unsigned.
   always_comb begin
      sum_c = '0;
      a     = '0;
      b     = '0;
      ad    = '0;
      sq    = '0;
      for (int i = 0; i < LANES; i++) begin
         a  = sample[i*LANE_W +: LANE_W];
         b  = word[i*LANE_W +: LANE_W];
         ad = (a >= b) ? (a - b) : (b - a);
         sq = {18'd0, ad} * {18'd0, ad};
         if (mask[i]) begin
            sum_c = sum_c + {2'b00, sq};
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum <= '0;
      end else begin
         sum <= sum_c;
      end
   end

endmodule

// File: rtl/sofm_bmu_search.sv
// Best-matching-unit search: caches one sample, scans all neuron weights and
// reports the coordinates and squared distance of the closest neuron.
module sofm_bmu_search
   import sofm_pkg::*;
#(
   parameter int MAX_DIM = 1024,
   parameter int ADDR_W  = 20,
   parameter int COORD_W = 8,
   parameter int ACC_W   = 48
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [15:0]        dim,
   input  logic [COORD_W-1:0] len,
   input  logic [COORD_W-1:0] wid,
   input  logic [ADDR_W-1:0]  sample_base,
   input  logic [ADDR_W-1:0]  map_base,
   output logic               in_rd,
   output logic [ADDR_W-1:0]  in_addr,
   input  logic [15:0]        in_data,
   output logic               map_rd,
   output logic [ADDR_W-1:0]  map_addr,
   input  logic [WORD_W-1:0]  map_data,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [COORD_W-1:0] bmu_x,
   output logic [COORD_W-1:0] bmu_y,
   output logic [ACC_W-1:0]   bmu_dist
);

   localparam int BUF_WORDS = (MAX_DIM + LANES - 1) / LANES;
   localparam int BW_W      = $clog2(BUF_WORDS);

   state_t state, next_state;

   logic [15:0]        dim_q, wn_q, k, w_cnt;
   logic [COORD_W-1:0] len_q, wid_q, x_cnt, y_cnt;
   logic [ADDR_W-1:0]  sbase_q, mbase_q, scan_off;
   logic               drain_cnt;
   logic               illegal, load_last, word_last, scan_last;
   logic [LANES-1:0]   lane_mask;
   logic [17:0]        elem_base;
   logic [WORD_W-1:0]  buf_word;

   logic [WORD_W-1:0]  sample_buf [BUF_WORDS];

   logic [35:0]        s1_sum;
   logic               s1_valid, s1_first_word, s1_last_word, s1_first_nrn;
   logic [COORD_W-1:0] s1_x, s1_y;
   logic [ACC_W-1:0]   acc, acc_next, best;
   logic [COORD_W-1:0] best_x, best_y;

   assign illegal   = (dim == 16'd0) || (len == '0) || (wid == '0) || (dim > 16'(MAX_DIM));
   assign load_last = (k == dim_q - 16'd1);
   assign word_last = (w_cnt == wn_q - 16'd1);
   assign scan_last = word_last && (x_cnt == len_q - COORD_W'(1)) && (y_cnt == wid_q - COORD_W'(1));
   assign buf_word  = sample_buf[w_cnt[BW_W-1:0]];
   assign acc_next  = (s1_first_word ? '0 : acc) + ACC_W'(s1_sum);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      in_rd      = 1'b0;
      in_addr    = '0;
      map_rd     = 1'b0;
      map_addr   = '0;
      busy       = (state != IDLE);
      done       = 1'b0;
      case (state)
         IDLE:  if (start) next_state = illegal ? DONE : LOAD;
         LOAD: begin
            in_rd   = 1'b1;
            in_addr = sbase_q + ADDR_W'(k);
            if (load_last) next_state = SCAN;
         end
         SCAN: begin
            map_rd   = 1'b1;
            map_addr = mbase_q + scan_off;
            if (scan_last) next_state = DRAIN;
         end
         DRAIN: if (drain_cnt) next_state = DONE;
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Lanes past the end of the vector in a neuron's final word contribute 0.
   always_comb begin
      lane_mask = '0;
      elem_base = {w_cnt, 2'b00};
      for (int i = 0; i < LANES; i++) begin
         lane_mask[i] = (elem_base + 18'(i)) < {2'b00, dim_q};
      end
   end

   always_ff @(posedge clk) begin
      if (state == LOAD) begin
         sample_buf[k[BW_W+1:2]][k[1:0]*LANE_W +: LANE_W] <= in_data;
      end
   end

   // Scan order: word index innermost, then column, then row.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dim_q     <= '0;
         wn_q      <= '0;
         len_q     <= '0;
         wid_q     <= '0;
         sbase_q   <= '0;
         mbase_q   <= '0;
         k         <= '0;
         w_cnt     <= '0;
         x_cnt     <= '0;
         y_cnt     <= '0;
         scan_off  <= '0;
         drain_cnt <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               dim_q     <= dim;
               wn_q      <= words_per_neuron(dim);
               len_q     <= len;
               wid_q     <= wid;
               sbase_q   <= sample_base;
               mbase_q   <= map_base;
               k         <= '0;
               w_cnt     <= '0;
               x_cnt     <= '0;
               y_cnt     <= '0;
               scan_off  <= '0;
               drain_cnt <= 1'b0;
            end
            LOAD: k <= k + 16'd1;
            SCAN: begin
               scan_off <= scan_off + ADDR_W'(1);
               if (word_last) begin
                  w_cnt <= '0;
                  if (x_cnt == len_q - COORD_W'(1)) begin
                     x_cnt <= '0;
                     y_cnt <= y_cnt + COORD_W'(1);
                  end else begin
                     x_cnt <= x_cnt + COORD_W'(1);
                  end
               end else begin
                  w_cnt <= w_cnt + 16'd1;
               end
            end
            DRAIN: drain_cnt <= 1'b1;
            default: ;
         endcase
      end
   end

   sofm_sqdist4 u_sqdist (
      .clk    (clk),
      .rst    (rst),
      .word   (map_data),
      .sample (buf_word),
      .mask   (lane_mask),
      .sum    (s1_sum)
   );

   // Stage 2: accumulate per neuron; strict compare keeps the lowest index on ties.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid      <= 1'b0;
         s1_first_word <= 1'b0;
         s1_last_word  <= 1'b0;
         s1_first_nrn  <= 1'b0;
         s1_x          <= '0;
         s1_y          <= '0;
         acc           <= '0;
         best          <= '0;
         best_x        <= '0;
         best_y        <= '0;
      end else begin
         s1_valid      <= (state == SCAN);
         s1_first_word <= (w_cnt == 16'd0);
         s1_last_word  <= word_last;
         s1_first_nrn  <= (x_cnt == '0) && (y_cnt == '0);
         s1_x          <= x_cnt;
         s1_y          <= y_cnt;
         if (s1_valid) begin
            acc <= acc_next;
            if (s1_last_word && (s1_first_nrn || (acc_next < best))) begin
               best   <= acc_next;
               best_x <= s1_x;
               best_y <= s1_y;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err      <= 1'b0;
         bmu_x    <= '0;
         bmu_y    <= '0;
         bmu_dist <= '0;
      end else if ((state == IDLE) && start && illegal) begin
         err      <= 1'b1;
         bmu_x    <= '0;
         bmu_y    <= '0;
         bmu_dist <= '0;
      end else if ((state == DRAIN) && drain_cnt) begin
         err      <= 1'b0;
         bmu_x    <= best_x;
         bmu_y    <= best_y;
         bmu_dist <= best;
      end
   end

endmodule

// File: tb/tb_sofm_bmu_search.sv
// Directed self-checking bench for sofm_bmu_search with behavioural memories.
module tb_sofm_bmu_search;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] dim;
   logic [7:0]  len, wid;
   logic [19:0] sample_base, map_base;
   logic        in_rd, map_rd, busy, done, err;
   logic [19:0] in_addr, map_addr;
   logic [15:0] in_data;
   logic [63:0] map_data;
   logic [7:0]  bmu_x, bmu_y;
   logic [47:0] bmu_dist;

   logic [15:0] in_mem  [4096];
   logic [63:0] map_mem [4096];

   int compared   = 0;
   int mismatched = 0;

   int          in_reads = 0, map_reads = 0, both_cnt = 0, done_cnt = 0;
   logic [19:0] first_map = '0, last_map = '0;
   logic        prev_map_rd = 1'b0;

   int          run_cyc, run_in, run_map, run_both, run_done;

   always #5 clk = ~clk;

   assign in_data  = in_rd  ? in_mem[in_addr[11:0]]   : 16'h0;
   assign map_data = map_rd ? map_mem[map_addr[11:0]] : 64'h0;

   sofm_bmu_search dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dim         (dim),
      .len         (len),
      .wid         (wid),
      .sample_base (sample_base),
      .map_base    (map_base),
      .in_rd       (in_rd),
      .in_addr     (in_addr),
      .in_data     (in_data),
      .map_rd      (map_rd),
      .map_addr    (map_addr),
      .map_data    (map_data),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .bmu_x       (bmu_x),
      .bmu_y       (bmu_y),
      .bmu_dist    (bmu_dist)
   );

   always @(negedge clk) begin
      if (in_rd) in_reads <= in_reads + 1;
      if (map_rd) begin
         map_reads <= map_reads + 1;
         last_map  <= map_addr;
         if (!prev_map_rd) first_map <= map_addr;
      end
      prev_map_rd <= map_rd;
      if (in_rd && map_rd) both_cnt <= both_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Called at a negedge; start is sampled on the next posedge (cycle 0).
   task automatic applyStimulus(input logic [15:0] d, input logic [7:0] l, input logic [7:0] w,
                                input logic [19:0] sb, input logic [19:0] mb,
                                input int inj_cyc, input logic [15:0] inj_dim);
      int c, ir0, mr0, b0, dc0;
      ir0 = in_reads; mr0 = map_reads; b0 = both_cnt; dc0 = done_cnt;
      dim = d; len = l; wid = w; sample_base = sb; map_base = mb; start = 1'b1;
      @(posedge clk);
      c = 0;
      run_cyc = -1;
      while (c < 3000 && run_cyc < 0) begin
         @(negedge clk);
         c++;
         if (inj_cyc != 0 && c == inj_cyc) begin
            start = 1'b1;
            dim   = inj_dim;
         end else begin
            start = 1'b0;
         end
         if (done) run_cyc = c;
      end
      start = 1'b0;
      #1;
      run_in   = in_reads - ir0;
      run_map  = map_reads - mr0;
      run_both = both_cnt - b0;
      run_done = done_cnt - dc0;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; dim = '0; len = '0; wid = '0;
      sample_base = '0; map_base = '0;
      for (int i = 0; i < 4096; i++) begin
         in_mem[i]  = 16'h0;
         map_mem[i] = 64'h0;
      end
      in_mem[12'h010] = 16'd10; in_mem[12'h011] = 16'd20;
      in_mem[12'h012] = 16'd30; in_mem[12'h013] = 16'd40;
      map_mem[12'h201] = {16'd41, 16'd30, 16'd20, 16'd10};
      map_mem[12'h202] = {16'd40, 16'd30, 16'd20, 16'd10};
      map_mem[12'h203] = {16'd40, 16'd30, 16'd20, 16'd10};
      for (int i = 0; i < 5; i++) in_mem[12'h020 + i] = 16'd7;
      map_mem[12'h300] = {16'd7, 16'd7, 16'd7, 16'd7};
      map_mem[12'h301] = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0007};
      for (int i = 0; i < 784; i++) in_mem[12'h400 + i] = 16'hFFFF;

      repeat (2) @(negedge clk);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_err", err, 0);
      checkOutput("reset_strobes", {in_rd, map_rd}, 0);
      checkOutput("reset_addrs", {in_addr, map_addr}, 0);
      checkOutput("reset_bmu", {bmu_x, bmu_y, bmu_dist}, 0);
      rst = 1'b1;

      $display("[TB] basic 2x2 search");
      @(negedge clk);
      applyStimulus(16'd4, 8'd2, 8'd2, 20'h010, 20'h200, 0, 16'd0);
      checkOutput("basic_done_cycle", run_cyc, 11);
      checkOutput("basic_bmu_x", bmu_x, 0);
      checkOutput("basic_bmu_y", bmu_y, 1);
      checkOutput("basic_bmu_dist", bmu_dist, 0);
      checkOutput("basic_err", err, 0);
      checkOutput("basic_in_reads", run_in, 4);
      checkOutput("basic_map_reads", run_map, 4);
      checkOutput("basic_first_addr", first_map, 20'h200);
      checkOutput("basic_last_addr", last_map, 20'h203);
      checkOutput("basic_overlap", run_both, 0);

      $display("[TB] lane masking");
      @(negedge clk);
      applyStimulus(16'd5, 8'd1, 8'd1, 20'h020, 20'h300, 0, 16'd0);
      checkOutput("mask_done_cycle", run_cyc, 10);
      checkOutput("mask_bmu_dist", bmu_dist, 0);
      checkOutput("mask_map_reads", run_map, 2);
      checkOutput("mask_bmu_xy", {bmu_x, bmu_y}, 0);

      $display("[TB] width extreme");
      @(negedge clk);
      applyStimulus(16'd784, 8'd1, 8'd1, 20'h400, 20'h800, 0, 16'd0);
      checkOutput("wide_done_cycle", run_cyc, 983);
      checkOutput("wide_bmu_dist", bmu_dist, 64'd3367151600400);
      checkOutput("wide_first_addr", first_map, 20'h800);
      checkOutput("wide_last_addr", last_map, 20'h8C3);
      checkOutput("wide_map_reads", run_map, 196);
      checkOutput("wide_overlap", run_both, 0);

      $display("[TB] reset during scan");
      @(negedge clk);
      dim = 16'd4; len = 8'd2; wid = 8'd2; sample_base = 20'h010; map_base = 20'h200;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("abort_pre_map_rd", map_rd, 1);
      run_done = done_cnt;
      rst = 1'b0;
      #1;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_map_rd", map_rd, 0);
      checkOutput("abort_map_addr", map_addr, 0);
      checkOutput("abort_bmu_dist", bmu_dist, 0);
      repeat (4) @(negedge clk);
      #1;
      checkOutput("abort_no_done", done_cnt - run_done, 0);
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(16'd4, 8'd2, 8'd2, 20'h010, 20'h200, 0, 16'd0);
      checkOutput("restart_done_cycle", run_cyc, 11);
      checkOutput("restart_bmu_xy", {bmu_x, bmu_y}, {8'd0, 8'd1});
      checkOutput("restart_bmu_dist", bmu_dist, 0);

      $display("[TB] illegal parameters");
      @(negedge clk);
      applyStimulus(16'd0, 8'd1, 8'd1, 20'h010, 20'h200, 0, 16'd0);
      checkOutput("dim0_done_cycle", run_cyc, 1);
      checkOutput("dim0_err", err, 1);
      checkOutput("dim0_reads", run_in + run_map, 0);
      @(negedge clk);
      applyStimulus(16'd4, 8'd2, 8'd0, 20'h010, 20'h200, 0, 16'd0);
      checkOutput("wid0_done_cycle", run_cyc, 1);
      checkOutput("wid0_err", err, 1);
      checkOutput("wid0_reads", run_in + run_map, 0);
      @(negedge clk);
      applyStimulus(16'd1025, 8'd1, 8'd1, 20'h010, 20'h200, 0, 16'd0);
      checkOutput("big_done_cycle", run_cyc, 1);
      checkOutput("big_err", err, 1);
      checkOutput("big_reads", run_in + run_map, 0);
      checkOutput("big_bmu", {bmu_x, bmu_y, bmu_dist}, 0);

      $display("[TB] start while busy");
      @(negedge clk);
      applyStimulus(16'd5, 8'd1, 8'd1, 20'h020, 20'h300, 2, 16'd4);
      checkOutput("busy_done_cycle", run_cyc, 10);
      checkOutput("busy_in_reads", run_in, 5);
      checkOutput("busy_map_reads", run_map, 2);
      checkOutput("busy_done_pulses", run_done, 1);
      checkOutput("busy_err", err, 0);
      checkOutput("busy_bmu_dist", bmu_dist, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
